// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative radix-2 divider: FSM state encoding and default width.
package div_unit_pkg;

  localparam int unsigned DivWidth = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StZero = 2'd2,
    StDone = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, stalls the pipeline
// while iterating and pulses valid for one cycle when quotient/remainder are ready for HI/LO.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_sign,
  input  logic             annul,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  div_state_e       state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             sign_a_q, sign_b_q;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_wide;
  logic             ge;
  logic [WIDTH-1:0] step_rem, step_quo, fix_quo, fix_rem;

  always_comb begin
    abs_a = (is_sign && opa[WIDTH-1]) ? -opa : opa;
    abs_b = (is_sign && opb[WIDTH-1]) ? -opb : opb;
  end

  // One restoring step. The compare is WIDTH+1 bits so a divisor with its MSB set still
  // compares correctly; the difference is always below the divisor, so WIDTH bits suffice.
  always_comb begin
    rem_wide = {rem_q, quo_q[WIDTH-1]};
    ge       = (rem_wide >= {1'b0, dvsr_q});
    step_rem = ge ? (rem_wide[WIDTH-1:0] - dvsr_q) : rem_wide[WIDTH-1:0];
    step_quo = {quo_q[WIDTH-2:0], ge};
    fix_quo  = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
    fix_rem  = sign_a_q ? -step_rem : step_rem;
  end

  // Results are loaded on entry to StDone so they are visible while valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (annul) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sign_a_q <= is_sign & opa[WIDTH-1];
            sign_b_q <= is_sign & opb[WIDTH-1];
            rem_q    <= '0;
            quo_q    <= abs_a;
            dvsr_q   <= abs_b;
            count_q  <= '0;
            state_q  <= (opb == '0) ? StZero : StBusy;
          end
        end
        StBusy: begin
          rem_q   <= step_rem;
          quo_q   <= step_quo;
          count_q <= count_q + CntW'(1);
          if (count_q == LastCnt) begin
            state_q     <= StDone;
            quotient    <= fix_quo;
            remainder   <= fix_rem;
            div_by_zero <= 1'b0;
          end
        end
        StZero: begin
          state_q     <= StDone;
          quotient    <= '1;
          remainder   <= quo_q;
          div_by_zero <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    valid = ~rst & ~annul & (state_q == StDone);
    stall = ~rst & ~annul &
            (((state_q == StIdle) & start) | (state_q == StBusy) | (state_q == StZero));
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a driver issues divides and pushes expected results, a monitor
// pops and compares whenever valid pulses.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst, start, is_sign, annul;
  logic [31:0] opa, opb;
  logic        stall, valid, div_by_zero;
  logic [31:0] quotient, remainder;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_sign    (is_sign),
    .annul      (annul),
    .opa        (opa),
    .opb        (opb),
    .stall      (stall),
    .valid      (valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   last_valid_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && valid) begin
      last_valid_cyc = cyc;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue a divide in the current (IDLE) cycle, wait for valid, leave start held high.
  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er, input logic edz,
                     input int exp_stall, input logic scramble);
    exp_t e;
    int   stalls = 0;
    logic got = 1'b0;
    opa = a; opb = b; is_sign = s; start = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.cyc = cyc + (edz ? 2 : 33);
    sb.push_back(e);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (valid) got = 1'b1;
      else if (stall) stalls++;
      if (scramble && i == 3) begin
        opa = ~a;
        opb = 32'h3;
      end
    end
    chk("valid_seen", {31'd0, got}, 32'd1);
    chk("stall_cycles", stalls, exp_stall);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_cyc;
    rst = 1'b1; start = 1'b0; is_sign = 1'b0; annul = 1'b0; opa = '0; opb = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Operands are changed mid-BUSY; the result must use the values sampled in IDLE.
    run(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b1);

    // Annul at BUSY cycle 10 with previous result 14 r 2 still held.
    opa = 32'd50; opb = 32'd3; is_sign = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", {31'd0, stall}, 32'd0);
    chk("annul_valid", {31'd0, valid}, 32'd0);
    chk("annul_keep_q", quotient, 32'd14);
    chk("annul_keep_r", remainder, 32'd2);
    @(posedge clk); #1 annul = 1'b0;
    run(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 1'b0);

    // Annul in the start cycle itself.
    start = 1'b0;
    @(posedge clk); #1;
    opa = 32'd9; opb = 32'd0; start = 1'b1; annul = 1'b1;
    @(negedge clk);
    chk("annul_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 annul = 1'b0; start = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    run(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 1'b0);
    run(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 33, 1'b0);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 33, 1'b0);
    run(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 1'b0);
    run(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 2, 1'b0);

    // Reset at BUSY cycle 5 clears results (div_by_zero was 1).
    opa = 32'd9; opb = 32'd4; is_sign = 1'b0; start = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_mid_q", quotient, 32'd0);
    chk("rst_mid_r", remainder, 32'd0);
    chk("rst_mid_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_mid_valid", {31'd0, valid}, 32'd0);
    chk("rst_mid_stall2", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back divides.
    run(32'hDEAD_BEEF, 32'h10, 1'b0, 32'h0DEA_DBEE, 32'hF, 1'b0, 33, 1'b0);
    first_cyc = last_valid_cyc;
    run(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33, 1'b0);
    chk("b2b_spacing", last_valid_cyc - first_cyc, 32'd34);

    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
